// File: rtl/traffic_cl_seq_ctrl.sv
// Two-road intersection sequencer (Moore FSM): latches side-road car and pedestrian requests,
// times green/yellow/all-red phases and lets an emergency return right-of-way to the main road.
module traffic_cl_seq_ctrl #(
  parameter int CNT_W       = 6,
  parameter int T_MIN_GREEN = 8,
  parameter int T_MAX_GREEN = 32,
  parameter int T_YELLOW    = 3,
  parameter int T_ALL_RED   = 2
) (
  input  logic       clk_pad,
  input  logic       rst_n_pad,
  input  logic       side_car_pad,
  input  logic       ped_req_pad,
  input  logic       emerg_pad,
  output logic [1:0] main_light_pad,
  output logic [1:0] side_light_pad,
  output logic       walk_pad,
  output logic [2:0] state_pad
);

  typedef enum logic [2:0] {
    MG  = 3'd0,
    MY  = 3'd1,
    AR1 = 3'd2,
    SG  = 3'd3,
    SY  = 3'd4,
    AR2 = 3'd5
  } state_t;

  localparam logic [1:0] RED    = 2'b00;
  localparam logic [1:0] GREEN  = 2'b01;
  localparam logic [1:0] YELLOW = 2'b10;

  // Each phase ends on the cycle whose count equals its length minus one.
  localparam logic [CNT_W-1:0] MIN_G_LAST = CNT_W'(T_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_G_LAST = CNT_W'(T_MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_LAST   = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] AR_LAST    = CNT_W'(T_ALL_RED - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt;
  logic             side_pend, ped_pend, req, enter_sg;
  logic [1:0]       main_nxt, side_nxt;
  logic             walk_nxt;

  assign req       = side_pend | ped_pend;
  assign enter_sg  = (next_state == SG) && (state != SG);
  assign state_pad = state;

  // NOTE: every combinational output gets a default before the case so no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      MG:  if (req && !emerg_pad && cnt >= MIN_G_LAST) next_state = MY;
      MY:  if (cnt >= YEL_LAST) next_state = AR1;
      AR1: if (cnt >= AR_LAST) next_state = emerg_pad ? MG : SG;
      SG:  if (emerg_pad || cnt >= MAX_G_LAST || (!side_car_pad && cnt >= MIN_G_LAST))
             next_state = SY;
      SY:  if (cnt >= YEL_LAST) next_state = AR2;
      AR2: if (cnt >= AR_LAST) next_state = MG;
      default: next_state = MG;
    endcase
  end

  // Lights are decoded from next_state so they change together with state_pad.
  always_comb begin
    main_nxt = RED;
    side_nxt = RED;
    walk_nxt = 1'b0;
    case (next_state)
      MG: main_nxt = GREEN;
      MY: main_nxt = YELLOW;
      SG: begin
        side_nxt = GREEN;
        walk_nxt = 1'b1;
      end
      SY: side_nxt = YELLOW;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_pad) begin
    if (!rst_n_pad) begin
      state          <= MG;
      cnt            <= '0;
      side_pend      <= 1'b0;
      ped_pend       <= 1'b0;
      main_light_pad <= GREEN;
      side_light_pad <= RED;
      walk_pad       <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state != state) cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);

      // Entering side green serves the pending requests; that clear beats a same-cycle set.
      if (enter_sg) begin
        side_pend <= 1'b0;
        ped_pend  <= 1'b0;
      end else begin
        if (side_car_pad) side_pend <= 1'b1;
        if (ped_req_pad)  ped_pend  <= 1'b1;
      end

      main_light_pad <= main_nxt;
      side_light_pad <= side_nxt;
      walk_pad       <= walk_nxt;
    end
  end

endmodule

// File: tb/tb_traffic_cl_seq_ctrl.sv
// Scoreboard bench for traffic_cl_seq_ctrl: stimulus pushes the hand-derived expected state of
// every cycle; a monitor pops it mid-cycle and checks state, lights, walk and the no-conflict rule.
module tb_traffic_cl_seq_ctrl;

  localparam logic [2:0] S_MG = 3'd0, S_MY = 3'd1, S_AR1 = 3'd2,
                         S_SG = 3'd3, S_SY = 3'd4, S_AR2 = 3'd5;

  logic       clk_pad = 1'b0;
  logic       rst_n_pad = 1'b0;
  logic       side_car_pad = 1'b0;
  logic       ped_req_pad = 1'b0;
  logic       emerg_pad = 1'b0;
  logic [1:0] main_light_pad, side_light_pad;
  logic       walk_pad;
  logic [2:0] state_pad;

  logic [2:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;
  string      scen = "init";

  traffic_cl_seq_ctrl dut (
    .clk_pad        (clk_pad),
    .rst_n_pad      (rst_n_pad),
    .side_car_pad   (side_car_pad),
    .ped_req_pad    (ped_req_pad),
    .emerg_pad      (emerg_pad),
    .main_light_pad (main_light_pad),
    .side_light_pad (side_light_pad),
    .walk_pad       (walk_pad),
    .state_pad      (state_pad)
  );

  always #5 clk_pad = ~clk_pad;

  // Expected {main, side, walk} for a state code.
  function automatic logic [4:0] lights_of(input logic [2:0] s);
    case (s)
      S_MG:    return 5'b01_00_0;
      S_MY:    return 5'b10_00_0;
      S_SG:    return 5'b00_01_1;
      S_SY:    return 5'b00_10_0;
      default: return 5'b00_00_0;
    endcase
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s [%s] at %0t: got %b, want %b", name, scen, $time, got, want);
    end
  endtask

  // Monitor: one expected entry per cycle, sampled on the falling edge.
  initial begin : monitor
    logic [2:0] e;
    forever begin
      @(negedge clk_pad);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("state_lights", {state_pad, main_light_pad, side_light_pad, walk_pad},
              {e, lights_of(e)});
        check("no_conflict", {7'd0, (main_light_pad != 2'b00) && (side_light_pad != 2'b00)}, 8'd0);
      end
    end
  end

  task automatic step(input logic r, input logic s, input logic p, input logic em,
                      input logic [2:0] st);
    rst_n_pad    = r;
    side_car_pad = s;
    ped_req_pad  = p;
    emerg_pad    = em;
    exp_q.push_back(st);
    @(posedge clk_pad);
    #1;
  endtask

  task automatic seg(input int n, input logic s, input logic p, input logic em,
                     input logic [2:0] st);
    for (int i = 0; i < n; i++) step(1'b1, s, p, em, st);
  endtask

  task automatic do_reset(input string name);
    scen         = name;
    rst_n_pad    = 1'b0;
    side_car_pad = 1'b0;
    ped_req_pad  = 1'b0;
    emerg_pad    = 1'b0;
    @(posedge clk_pad);
    #1;
    rst_n_pad = 1'b1;
  endtask

  // One full side phase with no inputs: MY, AR1, SG (sensor low), SY, AR2.
  task automatic side_cycle();
    seg(3, 0, 0, 0, S_MY);
    seg(2, 0, 0, 0, S_AR1);
    seg(8, 0, 0, 0, S_SG);
    seg(3, 0, 0, 0, S_SY);
    seg(2, 0, 0, 0, S_AR2);
  endtask

  initial begin
    // 1: idle after reset stays on main green.
    do_reset("idle");
    seg(100, 0, 0, 0, S_MG);

    // 2: single car pulse at cycle 2 -> MY@8, AR1@11, SG@13, SY@21, AR2@24, MG@26.
    do_reset("car_pulse");
    seg(2, 0, 0, 0, S_MG);
    seg(1, 1, 0, 0, S_MG);
    seg(5, 0, 0, 0, S_MG);
    side_cycle();
    seg(20, 0, 0, 0, S_MG);

    // 3: sensor held high -> SG lasts the max 32 cycles; pend re-sets, so MY after min green.
    do_reset("car_held");
    seg(8, 1, 0, 0, S_MG);
    seg(3, 1, 0, 0, S_MY);
    seg(2, 1, 0, 0, S_AR1);
    seg(32, 1, 0, 0, S_SG);
    seg(3, 1, 0, 0, S_SY);
    seg(2, 1, 0, 0, S_AR2);
    seg(8, 1, 0, 0, S_MG);
    side_cycle();
    seg(10, 0, 0, 0, S_MG);

    // 4: ped pulse sampled on the SG-entry edge is dropped; one inside SG earns a second phase.
    do_reset("ped");
    seg(1, 0, 1, 0, S_MG);
    seg(7, 0, 0, 0, S_MG);
    seg(3, 0, 0, 0, S_MY);
    seg(1, 0, 0, 0, S_AR1);
    seg(1, 0, 1, 0, S_AR1);
    seg(8, 0, 0, 0, S_SG);
    seg(3, 0, 0, 0, S_SY);
    seg(2, 0, 0, 0, S_AR2);
    seg(20, 0, 0, 0, S_MG);
    seg(1, 0, 1, 0, S_MG);
    seg(1, 0, 0, 0, S_MG);
    seg(3, 0, 0, 0, S_MY);
    seg(2, 0, 0, 0, S_AR1);
    seg(3, 0, 0, 0, S_SG);
    seg(1, 0, 1, 0, S_SG);
    seg(4, 0, 0, 0, S_SG);
    seg(3, 0, 0, 0, S_SY);
    seg(2, 0, 0, 0, S_AR2);
    seg(8, 0, 0, 0, S_MG);
    side_cycle();
    seg(10, 0, 0, 0, S_MG);

    // 5: emergency on SG cycle 4 ends green, yellow/all-red still timed, MG holds until release.
    do_reset("emerg_sg");
    seg(1, 1, 0, 0, S_MG);
    seg(7, 0, 0, 0, S_MG);
    seg(3, 0, 0, 0, S_MY);
    seg(2, 0, 0, 0, S_AR1);
    seg(4, 0, 0, 0, S_SG);
    seg(1, 1, 0, 1, S_SG);
    seg(3, 0, 0, 1, S_SY);
    seg(2, 0, 0, 1, S_AR2);
    seg(12, 0, 0, 1, S_MG);
    seg(1, 0, 0, 0, S_MG);
    side_cycle();
    seg(5, 0, 0, 0, S_MG);

    // 6: emergency in AR1 returns to MG keeping the pend; emergency in MY keeps full yellow.
    do_reset("emerg_ar1");
    seg(1, 1, 0, 0, S_MG);
    seg(7, 0, 0, 0, S_MG);
    seg(3, 0, 0, 0, S_MY);
    seg(1, 0, 0, 0, S_AR1);
    seg(1, 0, 0, 1, S_AR1);
    seg(8, 0, 0, 0, S_MG);
    seg(3, 0, 0, 1, S_MY);
    seg(2, 0, 0, 1, S_AR1);
    seg(8, 0, 0, 0, S_MG);
    side_cycle();
    seg(5, 0, 0, 0, S_MG);

    // 7: reset during SY (with requests asserted) returns to MG with both pends cleared.
    do_reset("reset_sy");
    seg(1, 1, 0, 0, S_MG);
    seg(7, 0, 0, 0, S_MG);
    seg(3, 0, 0, 0, S_MY);
    seg(2, 0, 0, 0, S_AR1);
    seg(8, 0, 0, 0, S_SG);
    seg(1, 1, 1, 0, S_SY);
    step(1'b0, 1'b1, 1'b1, 1'b0, S_SY);
    seg(20, 0, 0, 0, S_MG);

    scen = "drain";
    repeat (3) @(negedge clk_pad);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected entries never checked, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
